lab2_seq_checker: RTL and testbench

Receive-side checker for the lab2 6-bit sequence stream. It consumes one 6-bit sample per valid cycle and locks onto the sequence at a 0 sample. It then recomputes the expected next term each cycle and flags every mismatch. It sits downstream of the sequence generator, or a link carrying its output, and provides pass/fail and period statistics for on-board LEDs/7-seg and for benches.

---
 rtl/lab2_seq_checker.sv | 99 +++++++++
 tb/tb_lab2_seq_checker.sv | 108 ++++++++++
 2 files changed

// File: rtl/lab2_seq_checker.sv
// lab2_seq_checker: locks onto the lab2 6-bit sequence stream and flags every term mismatch (optional relock on a 0 sample: LAB2_SEQ_CHECKER_RESYNC_EN)
module lab2_seq_checker #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [5:0]           in_data,
  output logic                 locked,
  output logic                 match,
  output logic                 err,
  output logic                 period_done,
  output logic [5:0]           expected,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  typedef enum logic {HUNT, TRACK} fsm_t;
  typedef enum logic {UP, DOWN} phase_t;
  fsm_t fsm, fsm_n;
  phase_t phase, phase_n;
  logic [5:0] n, n_n, prev, prev_n, exp_v, exp_n;
  logic [2:0] k, k_n;
  logic hit, miss, lock0, done_d;
  function automatic logic [5:0] exp_f(phase_t p, logic [5:0] pv, logic [5:0] nn, logic [2:0] kk);
    logic [6:0] s;
    s = p == DOWN ? {1'b0, pv} - (7'd1 << kk) :
        pv > nn   ? {1'b0, pv} - {1'b0, nn}   : {1'b0, pv} + {1'b0, nn};
    return s[5:0];
  endfunction
  assign locked = fsm == TRACK;
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= HUNT;
      phase       <= UP;
      n           <= '0;
      k           <= '0;
      prev        <= '0;
      match       <= 1'b0;
      err         <= 1'b0;
      period_done <= 1'b0;
      expected    <= '0;
      err_cnt     <= '0;
    end else begin
      fsm         <= fsm_n;
      phase       <= phase_n;
      n           <= n_n;
      k           <= k_n;
      prev        <= prev_n;
      match       <= hit;
      err         <= miss;
      period_done <= done_d;
      expected    <= exp_n;
      err_cnt     <= miss && !(&err_cnt) ? err_cnt + ERR_CNT_W'(1) : err_cnt;
    end
  end
  // next state: lock in HUNT, advance the term position on a match, drop (or relock) on a mismatch
  always_comb begin
    exp_v   = exp_f(phase, prev, n, k);
    lock0   = in_valid && fsm == HUNT && in_data == 6'd0;
    hit     = in_valid && fsm == TRACK && in_data == exp_v;
    miss    = in_valid && fsm == TRACK && in_data != exp_v;
    fsm_n   = fsm;
    phase_n = phase;
    n_n     = n;
    k_n     = k;
    prev_n  = prev;
    if (lock0) begin
      fsm_n   = TRACK;
      phase_n = UP;
      prev_n  = '0;
      n_n     = 6'd1;
    end else if (hit) begin
      prev_n = in_data;
      if (phase == UP) begin
        phase_n = in_data == 6'd63 ? DOWN : UP;
        k_n     = in_data == 6'd63 ? 3'd0 : k;
        n_n     = in_data == 6'd63 ? n : n + 6'd1;
      end else begin
        phase_n = in_data == 6'd0 ? UP : DOWN;
        n_n     = in_data == 6'd0 ? 6'd1 : n;
        k_n     = in_data == 6'd0 ? k : k + 3'd1;
      end
    end else if (miss) begin
`ifdef LAB2_SEQ_CHECKER_RESYNC_EN
      fsm_n   = in_data == 6'd0 ? TRACK : HUNT;
      phase_n = in_data == 6'd0 ? UP : phase;
      prev_n  = in_data == 6'd0 ? 6'd0 : prev;
      n_n     = in_data == 6'd0 ? 6'd1 : n;
`else
      fsm_n = HUNT;
`endif
    end
  end
  // output values presented after the edge
  always_comb begin
    done_d = hit && phase == DOWN && in_data == 6'd0;
    exp_n  = fsm_n == TRACK ? exp_f(phase_n, prev_n, n_n, k_n) : 6'd0;
  end
endmodule

// File: tb/tb_lab2_seq_checker.sv
// tb_lab2_seq_checker: scoreboard bench against a period-table reference model
module tb_lab2_seq_checker;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [5:0] in_data = 0;
  logic locked, match, err, period_done, locked2, match2, err2, pd2;
  logic [5:0] expected, expected2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  int compared = 0, mismatched = 0;
  int seq[63];
  bit m_lk = 0;
  int m_pos = 0, m_cnt = 0;
  typedef struct {bit m, e, pd, lk; int ex, ec, ec2;} rec_t;
  rec_t q[$];

  lab2_seq_checker dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .locked(locked),
    .match(match), .err(err), .period_done(period_done), .expected(expected), .err_cnt(err_cnt));
  lab2_seq_checker #(.ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .locked(locked2), .match(match2), .err(err2), .period_done(pd2), .expected(expected2), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  function automatic int nxt();
    return seq[(m_pos + 1) % 63];
  endfunction

  task automatic chk(string nm, int act, int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  task automatic cyc(bit r, bit v, int d);
    rec_t x;
    @(negedge clk);
    rst = r; in_valid = v; in_data = 6'(d);
    x = '{default: 0};
    if (r) begin
      m_lk = 0; m_pos = 0; m_cnt = 0;
    end else if (v && !m_lk) begin
      if (d == 0) begin m_lk = 1; m_pos = 0; end
    end else if (v) begin
      if (d == nxt()) begin
        x.m = 1; m_pos = (m_pos + 1) % 63; x.pd = m_pos == 0;
      end else begin
        x.e = 1; m_cnt++;
`ifdef LAB2_SEQ_CHECKER_RESYNC_EN
        if (d == 0) m_pos = 0; else m_lk = 0;
`else
        m_lk = 0;
`endif
      end
    end
    x.lk = m_lk; x.ex = m_lk ? nxt() : 0;
    x.ec = m_cnt > 255 ? 255 : m_cnt; x.ec2 = m_cnt > 3 ? 3 : m_cnt;
    q.push_back(x);
  endtask

  initial forever begin
    rec_t x;
    @(posedge clk); #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("match", int'(match), int'(x.m));
      chk("err", int'(err), int'(x.e));
      chk("period_done", int'(period_done), int'(x.pd));
      chk("locked", int'(locked), int'(x.lk));
      chk("expected", int'(expected), x.ex);
      chk("err_cnt", int'(err_cnt), x.ec);
      chk("err_cnt_w2", int'(err_cnt2), x.ec2);
      chk("w2_pulses", int'({match2, err2, pd2, locked2}), int'({x.m, x.e, x.pd, x.lk}));
      chk("w2_expected", int'(expected2), x.ex);
    end
  end

  initial begin
    seq[0] = 0;
    for (int i = 1; i <= 57; i++) seq[i] = seq[i-1] > i ? seq[i-1] - i : seq[i-1] + i;
    for (int i = 0; i < 5; i++) seq[58+i] = seq[57+i] - (1 << i);
    cyc(1, 0, 0);
    for (int i = 0; i < 64; i++) cyc(0, 1, seq[i % 63]);
    cyc(1, 0, 0);
    for (int i = 0; i < 64; i++) begin cyc(0, 1, seq[i % 63]); cyc(0, 0, $urandom_range(63)); end
    cyc(1, 0, 0);
    foreach (seq[i]) if (i < 4) cyc(0, 1, i == 3 ? 5 : seq[i]);
    cyc(0, 1, 6); cyc(0, 1, 0); cyc(0, 1, 1);
    cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 3); cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 3);
    cyc(1, 0, 0);
    for (int i = 0; i <= 10; i++) cyc(0, 1, seq[i]);
    cyc(1, 1, seq[11]);
    cyc(0, 1, 0); cyc(0, 1, 1);
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) begin cyc(0, 1, 0); cyc(0, 1, 9); end
    for (int i = 0; i < 3000; i++) begin
      int p, d;
      p = $urandom_range(99);
      d = !m_lk ? (p < 30 ? 0 : $urandom_range(63)) : p < 88 ? nxt() : p < 93 ? 0 : $urandom_range(63);
      cyc($urandom_range(299) == 0, $urandom_range(3) != 0, d);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
